id_ex_issue: RTL

- ID/EX issue register for the pipelined core, on the producer side of the execute-stage operand interface.
- Captures decoded fields from ID and presents the EX operand bundle: pc, ALU select, immediate, branch-unsigned flag, A/B operand selects, rs1/rs2 data.
- Forwards rs1/rs2 from MEM and WB, detects load-use hazards, inserts bubbles on branch flush, and freezes on back-end hold.
- Keeps saturating stall/flush event counters.

---
 rtl/id_ex_issue.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_issue.sv
// ID/EX issue register: captures decoded ID fields, forwards rs1/rs2 from
// MEM/WB into EX, and handles load-use stalls, flush bubbles and back-end hold.
module id_ex_issue #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [XLEN-1:0]  i_id_pc,
    input  logic [3:0]       i_id_alu_sel,
    input  logic [XLEN-1:0]  i_id_imm,
    input  logic             i_id_brun,
    input  logic             i_id_a_sel,
    input  logic             i_id_b_sel,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [XLEN-1:0]  i_id_rs1_data,
    input  logic [XLEN-1:0]  i_id_rs2_data,
    input  logic [4:0]       i_id_rd_addr,
    input  logic             i_id_rd_wren,
    input  logic             i_id_mem_rden,
    input  logic [4:0]       i_mem_rd_addr,
    input  logic             i_mem_rd_wren,
    input  logic [XLEN-1:0]  i_mem_alu_data,
    input  logic [4:0]       i_wb_rd_addr,
    input  logic             i_wb_rd_wren,
    input  logic [XLEN-1:0]  i_wb_data,
    input  logic             i_flush,
    input  logic             i_hold,
    output logic             o_id_stall,
    output logic             o_ex_valid,
    output logic [XLEN-1:0]  o_ex_pc,
    output logic [XLEN-1:0]  o_ex_imm,
    output logic [3:0]       o_ex_alu_sel,
    output logic             o_ex_brun,
    output logic             o_ex_a_sel,
    output logic             o_ex_b_sel,
    output logic [XLEN-1:0]  o_ex_rs1_data,
    output logic [XLEN-1:0]  o_ex_rs2_data,
    output logic [4:0]       o_ex_rd_addr,
    output logic             o_ex_rd_wren,
    output logic             o_ex_mem_rden,
    output logic [CNT_W-1:0] o_loaduse_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [3:0]       r_alu_sel;
    logic [XLEN-1:0]  r_imm;
    logic             r_brun;
    logic             r_a_sel;
    logic             r_b_sel;
    logic [4:0]       r_rs1_addr;
    logic [4:0]       r_rs2_addr;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [4:0]       r_rd_addr;
    logic             r_rd_wren;
    logic             r_mem_rden;
    logic [CNT_W-1:0] r_loaduse_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_loaduse;
    logic             w_bubble;
    logic             w_flush_evt;
    logic             w_lu_evt;
    logic [XLEN-1:0]  w_rs1_fwd;
    logic [XLEN-1:0]  w_rs2_fwd;
    logic [XLEN-1:0]  w_rs1_cap;
    logic [XLEN-1:0]  w_rs2_cap;

    always_comb begin
        w_rs1_hit = i_id_rs1_used && (i_id_rs1_addr == r_rd_addr);
        w_rs2_hit = i_id_rs2_used && (i_id_rs2_addr == r_rd_addr);
        w_loaduse = r_valid && r_mem_rden && r_rd_wren
                    && (r_rd_addr != 5'd0) && i_id_valid
                    && (w_rs1_hit || w_rs2_hit);
    end

    assign o_id_stall  = !i_flush && (i_hold || w_loaduse);
    assign w_bubble    = i_flush || (!i_hold && w_loaduse);
    assign w_flush_evt = i_flush && (i_id_valid || r_valid);
    assign w_lu_evt    = !i_flush && !i_hold && w_loaduse;

    // EX operands: MEM result beats WB, x0 is never overridden
    always_comb begin
        w_rs1_fwd = r_rs1_data;
        if (r_rs1_addr != 5'd0) begin
            if (i_mem_rd_wren && (i_mem_rd_addr == r_rs1_addr))
                w_rs1_fwd = i_mem_alu_data;
            else if (i_wb_rd_wren && (i_wb_rd_addr == r_rs1_addr))
                w_rs1_fwd = i_wb_data;
        end
    end

    always_comb begin
        w_rs2_fwd = r_rs2_data;
        if (r_rs2_addr != 5'd0) begin
            if (i_mem_rd_wren && (i_mem_rd_addr == r_rs2_addr))
                w_rs2_fwd = i_mem_alu_data;
            else if (i_wb_rd_wren && (i_wb_rd_addr == r_rs2_addr))
                w_rs2_fwd = i_wb_data;
        end
    end

    // Regfile read races a same-cycle WB write; take the WB value
    always_comb begin
        w_rs1_cap = i_id_rs1_data;
        w_rs2_cap = i_id_rs2_data;
        if ((i_id_rs1_addr != 5'd0) && i_wb_rd_wren
            && (i_wb_rd_addr == i_id_rs1_addr))
            w_rs1_cap = i_wb_data;
        if ((i_id_rs2_addr != 5'd0) && i_wb_rd_wren
            && (i_wb_rd_addr == i_id_rs2_addr))
            w_rs2_cap = i_wb_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_bubble) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_alu_sel  <= '0;
            r_imm      <= '0;
            r_brun     <= 1'b0;
            r_a_sel    <= 1'b0;
            r_b_sel    <= 1'b0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rd_addr  <= '0;
            r_rd_wren  <= 1'b0;
            r_mem_rden <= 1'b0;
        end else if (i_hold) begin
            r_rs1_data <= w_rs1_fwd;
            r_rs2_data <= w_rs2_fwd;
        end else begin
            r_valid    <= i_id_valid;
            r_pc       <= i_id_pc;
            r_alu_sel  <= i_id_alu_sel;
            r_imm      <= i_id_imm;
            r_brun     <= i_id_brun;
            r_a_sel    <= i_id_a_sel;
            r_b_sel    <= i_id_b_sel;
            r_rs1_addr <= i_id_rs1_addr;
            r_rs2_addr <= i_id_rs2_addr;
            r_rs1_data <= w_rs1_cap;
            r_rs2_data <= w_rs2_cap;
            r_rd_addr  <= i_id_rd_addr;
            r_rd_wren  <= i_id_valid && i_id_rd_wren;
            r_mem_rden <= i_id_valid && i_id_mem_rden;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_loaduse_cnt <= '0;
            r_flush_cnt   <= '0;
        end else begin
            if (w_flush_evt && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (w_lu_evt && (r_loaduse_cnt != '1))
                r_loaduse_cnt <= r_loaduse_cnt + CNT_W'(1);
        end
    end

    assign o_ex_valid    = r_valid;
    assign o_ex_pc       = r_pc;
    assign o_ex_imm      = r_imm;
    assign o_ex_alu_sel  = r_alu_sel;
    assign o_ex_brun     = r_brun;
    assign o_ex_a_sel    = r_a_sel;
    assign o_ex_b_sel    = r_b_sel;
    assign o_ex_rs1_data = w_rs1_fwd;
    assign o_ex_rs2_data = w_rs2_fwd;
    assign o_ex_rd_addr  = r_rd_addr;
    assign o_ex_rd_wren  = r_rd_wren;
    assign o_ex_mem_rden = r_mem_rden;
    assign o_loaduse_cnt = r_loaduse_cnt;
    assign o_flush_cnt   = r_flush_cnt;

endmodule
